// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating count of inserted bubbles.
module id_ex_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Stall,
    input  logic              i_Flush,
    input  logic              i_Valid_ID,
    input  logic [CTRL_W-1:0] i_Ctrl_ID,
    input  logic              i_MemRead_ID,
    input  logic [DATA_W-1:0] i_ADD1_ID,
    input  logic [DATA_W-1:0] i_RData1_ID,
    input  logic [DATA_W-1:0] i_RData2_ID,
    input  logic [DATA_W-1:0] i_SignExt_ID,
    input  logic [REG_W-1:0]  i_Rs_ID,
    input  logic [REG_W-1:0]  i_Rt_ID,
    input  logic [REG_W-1:0]  i_Rd_ID,
    output logic [DATA_W-1:0] o_ADD1_Ex,
    output logic [DATA_W-1:0] o_RData1_Ex,
    output logic [DATA_W-1:0] o_RData2_Ex,
    output logic [DATA_W-1:0] o_SignExt_Ex,
    output logic [REG_W-1:0]  o_Rs_Ex,
    output logic [REG_W-1:0]  o_Rt_Ex,
    output logic [REG_W-1:0]  o_Rd_Ex,
    output logic [CTRL_W-1:0] o_Ctrl_Ex,
    output logic              o_MemRead_Ex,
    output logic              o_Valid_Ex,
    output logic              o_Hazard,
    output logic [CNT_W-1:0]  o_BubbleCnt
);

    logic [DATA_W-1:0] r_add1;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;
    logic [DATA_W-1:0] r_signext;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_memread;
    logic              r_valid;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic w_hazard;
    logic w_bubble;
    logic w_load;

    // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign w_hazard = r_valid & r_memread & i_Valid_ID & (r_rt != '0) &
                      ((r_rt == i_Rs_ID) | (r_rt == i_Rt_ID));

    // Flush beats Stall; a hazard only inserts a bubble when the stage is not held.
    assign w_bubble = i_Flush | (~i_Stall & w_hazard);
    assign w_load   = ~i_Flush & ~i_Stall & ~w_hazard;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_add1       <= '0;
            r_rdata1     <= '0;
            r_rdata2     <= '0;
            r_signext    <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_ctrl       <= '0;
            r_memread    <= 1'b0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (w_bubble) begin
            r_ctrl    <= '0;
            r_memread <= 1'b0;
            r_valid   <= 1'b0;
            if (r_bubble_cnt != '1) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end else if (w_load) begin
            r_add1    <= i_ADD1_ID;
            r_rdata1  <= i_RData1_ID;
            r_rdata2  <= i_RData2_ID;
            r_signext <= i_SignExt_ID;
            r_rs      <= i_Rs_ID;
            r_rt      <= i_Rt_ID;
            r_rd      <= i_Rd_ID;
            r_valid   <= i_Valid_ID;
            r_ctrl    <= i_Valid_ID ? i_Ctrl_ID : '0;
            r_memread <= i_Valid_ID & i_MemRead_ID;
        end
    end

    assign o_ADD1_Ex    = r_add1;
    assign o_RData1_Ex  = r_rdata1;
    assign o_RData2_Ex  = r_rdata2;
    assign o_SignExt_Ex = r_signext;
    assign o_Rs_Ex      = r_rs;
    assign o_Rt_Ex      = r_rt;
    assign o_Rd_Ex      = r_rd;
    assign o_Ctrl_Ex    = r_ctrl;
    assign o_MemRead_Ex = r_memread;
    assign o_Valid_Ex   = r_valid;
    assign o_Hazard     = w_hazard;
    assign o_BubbleCnt  = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model (default and 2-bit counter instances).
module tb_id_ex_pipe;

    typedef struct packed {
        logic [31:0] add1, rd1, rd2, sx;
        logic [4:0]  rs, rt, rd;
        logic [7:0]  ctrl;
        logic        mr, v;
    } ex_t;

    typedef struct packed {
        logic        rst, stall, flush, valid, mr;
        logic [7:0]  ctrl;
        logic [31:0] add1, rd1, rd2, sx;
        logic [4:0]  rs, rt, rd;
    } in_t;

    typedef struct packed {
        ex_t         st;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        logic        hz;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, valid_id, mr_id;
    logic [7:0]  ctrl_id;
    logic [31:0] add1_id, rd1_id, rd2_id, sx_id;
    logic [4:0]  rs_id, rt_id, rd_id;

    ex_t         st_a, st_b;
    logic        hz_a, hz_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    id_ex_pipe dut (
        .i_Clk(clk), .i_Rst(rst), .i_Stall(stall), .i_Flush(flush),
        .i_Valid_ID(valid_id), .i_Ctrl_ID(ctrl_id), .i_MemRead_ID(mr_id),
        .i_ADD1_ID(add1_id), .i_RData1_ID(rd1_id), .i_RData2_ID(rd2_id), .i_SignExt_ID(sx_id),
        .i_Rs_ID(rs_id), .i_Rt_ID(rt_id), .i_Rd_ID(rd_id),
        .o_ADD1_Ex(st_a.add1), .o_RData1_Ex(st_a.rd1), .o_RData2_Ex(st_a.rd2), .o_SignExt_Ex(st_a.sx),
        .o_Rs_Ex(st_a.rs), .o_Rt_Ex(st_a.rt), .o_Rd_Ex(st_a.rd),
        .o_Ctrl_Ex(st_a.ctrl), .o_MemRead_Ex(st_a.mr), .o_Valid_Ex(st_a.v),
        .o_Hazard(hz_a), .o_BubbleCnt(cnt_a)
    );

    id_ex_pipe #(.CNT_W(2)) dut_sat (
        .i_Clk(clk), .i_Rst(rst), .i_Stall(stall), .i_Flush(flush),
        .i_Valid_ID(valid_id), .i_Ctrl_ID(ctrl_id), .i_MemRead_ID(mr_id),
        .i_ADD1_ID(add1_id), .i_RData1_ID(rd1_id), .i_RData2_ID(rd2_id), .i_SignExt_ID(sx_id),
        .i_Rs_ID(rs_id), .i_Rt_ID(rt_id), .i_Rd_ID(rd_id),
        .o_ADD1_Ex(st_b.add1), .o_RData1_Ex(st_b.rd1), .o_RData2_Ex(st_b.rd2), .o_SignExt_Ex(st_b.sx),
        .o_Rs_Ex(st_b.rs), .o_Rt_Ex(st_b.rt), .o_Rd_Ex(st_b.rd),
        .o_Ctrl_Ex(st_b.ctrl), .o_MemRead_Ex(st_b.mr), .o_Valid_Ex(st_b.v),
        .o_Hazard(hz_b), .o_BubbleCnt(cnt_b)
    );

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Behavioural model state: the architectural contents of the EX latch.
    ex_t  m_st;
    int   m_cnt, m_cnt2;
    logic m_hz;

    function automatic logic model_hazard(input ex_t s, input in_t x);
        return s.v && s.mr && x.valid && (s.rt != 0) && (s.rt == x.rs || s.rt == x.rt);
    endfunction

    function automatic in_t nop();
        in_t x;
        x = '0;
        return x;
    endfunction

    task automatic model_step(input in_t x);
        logic hz;
        hz = model_hazard(m_st, x);
        if (x.rst) begin
            m_st = '0; m_cnt = 0; m_cnt2 = 0;
        end else if (x.flush || (!x.stall && hz)) begin
            m_st.v = 0; m_st.ctrl = 0; m_st.mr = 0;
            m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
            m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
        end else if (!x.stall) begin
            m_st.add1 = x.add1; m_st.rd1 = x.rd1; m_st.rd2 = x.rd2; m_st.sx = x.sx;
            m_st.rs = x.rs; m_st.rt = x.rt; m_st.rd = x.rd;
            m_st.v    = x.valid;
            m_st.ctrl = x.valid ? x.ctrl : 8'h00;
            m_st.mr   = x.valid && x.mr;
        end
    endtask

    task automatic drive(input in_t x);
        exp_t e;
        @(posedge clk);
        #1;
        rst = x.rst; stall = x.stall; flush = x.flush; valid_id = x.valid; mr_id = x.mr;
        ctrl_id = x.ctrl; add1_id = x.add1; rd1_id = x.rd1; rd2_id = x.rd2; sx_id = x.sx;
        rs_id = x.rs; rt_id = x.rt; rd_id = x.rd;
        m_hz   = model_hazard(m_st, x);
        e.st   = m_st;
        e.cnt  = 16'(m_cnt);
        e.cnt2 = 2'(m_cnt2);
        e.hz   = m_hz;
        exp_q.push_back(e);
        model_step(x);
    endtask

    task automatic check_bit(input string nm, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, req, $time);
        end
    endtask

    task automatic check_st(input string nm, input ex_t act, input ex_t req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic check_val(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents a latch state and a hazard flag.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_st ("ex_state",      st_a, e.st);
                check_bit("hazard",        hz_a, e.hz);
                check_val("bubble_cnt",    cnt_a, e.cnt);
                check_st ("ex_state_sat",  st_b, e.st);
                check_bit("hazard_sat",    hz_b, e.hz);
                check_val("bubble_cnt_sat", {14'd0, cnt_b}, {14'd0, e.cnt2});
            end
        end
    end

    initial begin
        in_t x, prev;
        logic prev_hz;
        rst = 1; stall = 0; flush = 0; valid_id = 0; mr_id = 0; ctrl_id = 0;
        add1_id = 0; rd1_id = 0; rd2_id = 0; sx_id = 0; rs_id = 0; rt_id = 0; rd_id = 0;
        m_st = '0; m_cnt = 0; m_cnt2 = 0; m_hz = 0;
        repeat (2) @(posedge clk);

        // Reset state
        x = nop(); x.rst = 1; drive(x);

        // Pass-through
        x = nop(); x.valid = 1; x.add1 = 32'h104; x.rd1 = 32'hDEADBEEF; x.rd = 7; x.ctrl = 8'h5A;
        drive(x);
        x = nop(); drive(x);

        // Load-use: load writing r9, then consumer reading r9 presented twice
        x = nop(); x.valid = 1; x.mr = 1; x.rt = 9; x.rs = 1; x.ctrl = 8'h11; drive(x);
        x = nop(); x.valid = 1; x.rs = 9; x.rt = 3; x.rd = 4; x.ctrl = 8'h22; x.add1 = 32'h200;
        drive(x);
        drive(x);
        x = nop(); drive(x);

        // Zero register never hazards
        x = nop(); x.valid = 1; x.mr = 1; x.rt = 0; x.ctrl = 8'h33; drive(x);
        x = nop(); x.valid = 1; x.rs = 0; x.rt = 0; x.ctrl = 8'h44; drive(x);
        x = nop(); drive(x);

        // Stall+Flush collision, then stall alone for 3 edges
        x = nop(); x.valid = 1; x.ctrl = 8'h55; x.rd1 = 32'h12345678; drive(x);
        x = nop(); x.stall = 1; x.flush = 1; drive(x);
        x = nop(); x.valid = 1; x.ctrl = 8'h66; drive(x);
        x = nop(); x.stall = 1; x.valid = 1; x.ctrl = 8'h77; x.add1 = 32'hFFFF0000;
        repeat (3) drive(x);
        x = nop(); drive(x);

        // Saturation: 5 flushes from reset
        x = nop(); x.rst = 1; drive(x);
        x = nop(); x.flush = 1; x.valid = 1; x.ctrl = 8'h99;
        repeat (5) drive(x);
        x = nop(); drive(x);

        // Reset while a hazard is pending and two bubbles have been counted
        x = nop(); x.rst = 1; drive(x);
        x = nop(); x.flush = 1; drive(x);
        x = nop(); x.valid = 1; x.mr = 1; x.rt = 9; x.ctrl = 8'hA0; drive(x);
        x = nop(); x.valid = 1; x.mr = 1; x.rs = 9; x.rt = 9; x.ctrl = 8'hA1; drive(x);
        drive(x);
        x = nop(); x.valid = 1; x.rs = 9; x.rst = 1; drive(x);
        x = nop(); x.valid = 1; x.rs = 9; drive(x);
        x = nop(); drive(x);

        // Random traffic; upstream re-presents the ID instruction while Hazard is high
        prev = nop(); prev_hz = 0;
        for (int i = 0; i < 3000; i++) begin
            x.rst   = ($urandom_range(0, 63) == 0);
            x.stall = ($urandom_range(0, 7) == 0);
            x.flush = ($urandom_range(0, 9) == 0);
            if (prev_hz) begin
                x.valid = prev.valid; x.mr = prev.mr; x.ctrl = prev.ctrl;
                x.add1 = prev.add1; x.rd1 = prev.rd1; x.rd2 = prev.rd2; x.sx = prev.sx;
                x.rs = prev.rs; x.rt = prev.rt; x.rd = prev.rd;
            end else begin
                x.valid = ($urandom_range(0, 6) != 0);
                x.mr    = $urandom_range(0, 1) == 1;
                x.ctrl  = 8'($urandom);
                x.add1  = $urandom; x.rd1 = $urandom; x.rd2 = $urandom; x.sx = $urandom;
                x.rs    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
                x.rt    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
                x.rd    = 5'($urandom);
            end
            drive(x);
            prev = x;
            prev_hz = m_hz;
        end

        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of PC+4, register-read and sign-extend fields.
REQ-002 SHALL have parameter REG_W, default 5, width of register-specifier fields.
REQ-003 SHALL have parameter CTRL_W, default 8, width of the opaque EX/MEM/WB control word.
REQ-004 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-005 Clk  input  1  single clock; all state updates on rising edge; one clock, no other clock domain.
REQ-006 Rst  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-007 Stall  input  1  external hold request from a downstream stage.
REQ-008 Flush  input  1  squash request (branch/jump resolved taken).
REQ-009 Valid_ID  input  1  ID stage holds a real instruction.
REQ-010 Ctrl_ID  input  CTRL_W  decoded control word.
REQ-011 MemRead_ID  input  1  ID instruction is a load.
REQ-012 ADD1_ID, RData1_ID, RData2_ID, SignExt_ID  input  DATA_W each  PC+4, register read data 1/2, sign-extended immediate.
REQ-013 Rs_ID, Rt_ID, Rd_ID  input  REG_W each  instruction fields 25:21, 20:16, 15:11.
REQ-014 Outputs ADD1_Ex, RData1_Ex, RData2_Ex, SignExt_Ex (DATA_W), Rs_Ex, Rt_Ex, Rd_Ex (REG_W), Ctrl_Ex (CTRL_W), MemRead_Ex (1), Valid_Ex (1): registered EX-side copies.
REQ-015 Hazard  output  1  combinational load-use hazard; upstream SHALL hold PC and IF/ID while high.
REQ-016 BubbleCnt  output  CNT_W  registered count of inserted bubbles.

Function
REQ-017 Hazard SHALL equal Valid_Ex & MemRead_Ex & Valid_ID & (Rt_Ex != 0) & ((Rt_Ex == Rs_ID) | (Rt_Ex == Rt_ID)), purely combinational from current register state and ID inputs.
REQ-018 Per rising edge, action priority SHALL be: Rst > Flush > Stall > Hazard > Load.
REQ-019 Load: every _Ex register SHALL capture its _ID counterpart; latency exactly one cycle.
REQ-020 Load with Valid_ID=0: Valid_Ex<=0, Ctrl_Ex<=0, MemRead_Ex<=0; data and specifier fields still captured.
REQ-021 Stall: every output register, including BubbleCnt, SHALL hold its value; Hazard still evaluates combinationally.
REQ-022 Flush: Valid_Ex<=0, Ctrl_Ex<=0, MemRead_Ex<=0; data and specifier registers hold; BubbleCnt+1.
REQ-023 Hazard (no Rst/Flush/Stall): bubble insertion identical to Flush, including BubbleCnt+1; the ID instruction is not captured and SHALL be presented again next cycle.
REQ-024 After a bubble MemRead_Ex=0, so Hazard SHALL deassert the following cycle; a load-use pair costs exactly one bubble.
REQ-025 BubbleCnt SHALL saturate at all-ones; no wrap.
REQ-026 Flush and Stall together: Flush SHALL win (squash overrides hold).
REQ-027 Register index 0 SHALL never raise Hazard.

Reset
REQ-028 Rst=1 at an edge SHALL clear every output register, including BubbleCnt, to 0, overriding Flush, Stall and Hazard.
REQ-029 Rst asserted mid-stall or mid-bubble SHALL leave no residual state; first edge with Rst=0 performs a normal action per REQ-018.
REQ-030 Hazard SHALL read 0 while registers are in reset state (Valid_Ex=0).

Verification
REQ-031 Pass-through: Valid_ID=1, ADD1_ID=0x00000104, RData1_ID=0xDEADBEEF, Rd_ID=7, Ctrl_ID=0x5A -> next edge: same values on _Ex, Valid_Ex=1, Hazard=0.
REQ-032 Load-use: Ex holds load with Rt_Ex=9, MemRead_Ex=1; ID presents Rs_ID=9 -> Hazard=1; next edge: Valid_Ex=0, Ctrl_Ex=0, BubbleCnt=1; next edge: ID instruction captured, Hazard=0.
REQ-033 Zero-register: load with Rt_Ex=0, ID Rs_ID=0 -> Hazard=0, no bubble, BubbleCnt unchanged.
REQ-034 Stall/Flush collision: Stall=1 and Flush=1 same edge with Valid_Ex=1 -> Valid_Ex=0, BubbleCnt+1; Stall=1 alone for 3 edges -> all outputs constant.
REQ-035 Saturation: CNT_W=2, force 5 consecutive Flush edges -> BubbleCnt sequence 1,2,3,3,3.
REQ-036 Reset mid-operation: Rst=1 while Hazard=1 and BubbleCnt=2 -> next edge all outputs 0, Hazard=0.
